// File: rtl/mdu_sequencer.sv
// Issue/sequencing controller for the EX-stage multiply/divide unit: latches operands,
// times the fixed-latency mult/div cores, commits HI/LO and drives the D-stage stall.
module mdu_sequencer #(
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10,
  parameter int CNT_W   = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        cancel,
  input  logic        d_uses_mdu,
  output logic [31:0] core_a,
  output logic [31:0] core_b,
  output logic [1:0]  core_sel,
  input  logic [63:0] core_result,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        proto_err
);

  if (MUL_LAT < 1 || DIV_LAT < 1 || MUL_LAT >= (1 << CNT_W) || DIV_LAT >= (1 << CNT_W))
  begin : g_lat_check
    $error("mdu_sequencer: latencies must be >=1 and fit in CNT_W bits");
  end

  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_LAT);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      a_q, a_d, b_q, b_d;
  logic [1:0]       sel_q, sel_d;
  logic             div0_q, div0_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic             perr_q, perr_d;

  logic       accept, is_mul, is_div, last_cycle;
  logic [1:0] op_sel;

  always_comb begin
    op_sel = 2'd0;
    case (op)
      3'd2:    op_sel = 2'd1;
      3'd3:    op_sel = 2'd2;
      3'd4:    op_sel = 2'd3;
      default: op_sel = 2'd0;
    endcase
  end

  assign is_mul     = (op == 3'd1) || (op == 3'd2);
  assign is_div     = (op == 3'd3) || (op == 3'd4);
  assign busy       = (state_q != S_IDLE);
  assign accept     = op_valid && !cancel && (state_q == S_IDLE);
  assign last_cycle = (state_q == S_MUL) ? (cnt_q == MUL_LAST) : (cnt_q == DIV_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sel_d   = sel_q;
    div0_d  = div0_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    perr_d  = perr_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (is_mul || is_div) begin
            a_d     = src_a;
            b_d     = src_b;
            sel_d   = op_sel;
            div0_d  = is_div && (src_b == 32'd0);
            cnt_d   = CNT_ONE;
            state_d = is_mul ? S_MUL : S_DIV;
          end else if (op == 3'd5) begin
            hi_d = src_a;
          end else if (op == 3'd6) begin
            lo_d = src_a;
          end
        end
      end
      S_MUL, S_DIV: begin
        if (last_cycle) begin
          // A zero divisor still burns the full latency but leaves HI/LO untouched.
          if (!(state_q == S_DIV && div0_q)) begin
            hi_d = core_result[63:32];
            lo_d = core_result[31:0];
          end
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (op_valid && ((busy && op != 3'd0) || op == 3'd7)) perr_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= '0;
      div0_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sel_q   <= sel_d;
      div0_q  <= div0_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      perr_q  <= perr_d;
    end
  end

  // Cores see the live EX operands when idle so they can start in the issue cycle.
  assign core_a    = busy ? a_q : src_a;
  assign core_b    = busy ? b_q : src_b;
  assign core_sel  = busy ? sel_q : op_sel;
  assign stall     = d_uses_mdu && (busy || (accept && (is_mul || is_div)));
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign proto_err = perr_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed bench for mdu_sequencer: behavioural mult/div core plus a scoreboard of
// expected {HI,LO} values pushed at issue and popped when the op retires.
module tb_mdu_sequencer;

  logic        clk = 1'b0;
  logic        reset, op_valid, cancel, d_uses_mdu;
  logic [2:0]  op;
  logic [31:0] src_a, src_b, core_a, core_b, hi, lo;
  logic [1:0]  core_sel;
  logic [63:0] core_result;
  logic        busy, stall, proto_err;

  int n_cmp = 0;
  int n_fail = 0;
  logic [63:0] exp_q[$];

  mdu_sequencer #(.MUL_LAT(5), .DIV_LAT(10), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op(op), .src_a(src_a), .src_b(src_b),
    .cancel(cancel), .d_uses_mdu(d_uses_mdu), .core_a(core_a), .core_b(core_b),
    .core_sel(core_sel), .core_result(core_result), .busy(busy), .stall(stall),
    .hi(hi), .lo(lo), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  // Behavioural external cores; divide-by-zero returns junk that must never be committed.
  logic signed [63:0] pa, pb;
  logic signed [31:0] sa, sb;
  always_comb begin
    core_result = 64'd0;
    pa = {{32{core_a[31]}}, core_a};
    pb = {{32{core_b[31]}}, core_b};
    sa = core_a;
    sb = core_b;
    case (core_sel)
      2'd0: core_result = pa * pb;
      2'd1: core_result = {32'd0, core_a} * {32'd0, core_b};
      2'd2: core_result = (core_b == 0) ? 64'hDEADBEEF_CAFEF00D : {32'(sa % sb), 32'(sa / sb)};
      2'd3: core_result = (core_b == 0) ? 64'hDEADBEEF_CAFEF00D : {core_a % core_b, core_a / core_b};
      default: core_result = 64'd0;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pop_chk(input string tag);
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $error("FAIL %s observed=scoreboard-empty expected=entry", tag);
    end else begin
      chk(tag, {hi, lo}, exp_q.pop_front());
    end
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic c);
    op = o; src_a = a; src_b = b; op_valid = 1'b1; cancel = c;
    tick();
    op_valid = 1'b0; cancel = 1'b0; op = 3'd0;
  endtask

  // Counts busy (and stall) cycles after an issue; bounded so a stuck DUT still finishes.
  task automatic wait_done(input string tag, input int lat, output int nstall);
    int nbusy;
    nbusy = 0;
    nstall = 0;
    while (busy && nbusy < 100) begin
      nbusy++;
      if (stall) nstall++;
      tick();
    end
    chk(tag, 64'(nbusy), 64'(lat));
  endtask

  initial begin
    int ns;
    int nb;
    reset = 1'b1; op_valid = 1'b0; op = 3'd0; cancel = 1'b0; d_uses_mdu = 1'b0;
    src_a = 32'd0; src_b = 32'd0;
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    chk("rst_perr", 64'(proto_err), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);

    // 1: signed multiply
    exp_q.push_back(64'hFFFFFFFF_FFFFFFEB);
    issue(3'd1, 32'hFFFFFFFD, 32'd7, 1'b0);
    wait_done("mult_lat", 5, ns);
    pop_chk("mult_res");
    chk("mult_idle", 64'(busy), 64'd0);
    $display("txn mult  -3*7 hi=%h lo=%h", hi, lo);

    // 2: unsigned multiply with D-stage stall
    d_uses_mdu = 1'b1;
    op = 3'd2; src_a = 32'hFFFFFFFF; src_b = 32'd2; op_valid = 1'b1;
    #1;
    chk("stall_issue", 64'(stall), 64'd1);
    chk("sel_pass", 64'(core_sel), 64'd1);
    exp_q.push_back(64'h00000001_FFFFFFFE);
    tick();
    op_valid = 1'b0; op = 3'd0;
    wait_done("multu_lat", 5, ns);
    chk("stall_busy", 64'(ns), 64'd5);
    pop_chk("multu_res");
    chk("stall_after", 64'(stall), 64'd0);
    d_uses_mdu = 1'b0;
    $display("txn multu FFFFFFFF*2 hi=%h lo=%h", hi, lo);

    // 3: signed divide, then divide by zero leaves HI/LO alone
    exp_q.push_back(64'hFFFFFFFF_FFFFFFFD);
    issue(3'd3, 32'hFFFFFFF9, 32'd2, 1'b0);
    wait_done("div_lat", 10, ns);
    pop_chk("div_res");
    $display("txn div   -7/2 hi=%h lo=%h", hi, lo);
    issue(3'd5, 32'd1, 32'd0, 1'b0);
    issue(3'd6, 32'd2, 32'd0, 1'b0);
    chk("mt_hilo", {hi, lo}, {32'd1, 32'd2});
    exp_q.push_back({32'd1, 32'd2});
    issue(3'd4, 32'd7, 32'd0, 1'b0);
    wait_done("div0_lat", 10, ns);
    pop_chk("div0_res");
    $display("txn divu  7/0 hi=%h lo=%h", hi, lo);

    // 4: cancellation in the issue cycle
    issue(3'd1, 32'd5, 32'd5, 1'b1);
    chk("cancel_busy", 64'(busy), 64'd0);
    tick(); tick();
    chk("cancel_hilo", {hi, lo}, {32'd1, 32'd2});
    issue(3'd5, 32'd1234, 32'd0, 1'b1);
    chk("cancel_mthi", 64'(hi), 64'd1);
    issue(3'd6, 32'd5678, 32'd0, 1'b0);
    chk("mtlo", 64'(lo), 64'd5678);
    $display("txn cancel/mt hi=%h lo=%h", hi, lo);

    // 5: cancel and a second op while a divide is in flight
    exp_q.push_back({32'd2, 32'd14});
    issue(3'd3, 32'd100, 32'd7, 1'b0);
    nb = 0;
    while (busy && nb < 100) begin
      nb++;
      cancel = (nb == 3);
      if (nb == 4) begin
        op_valid = 1'b1; op = 3'd3; src_a = 32'd9; src_b = 32'd3;
        #1;
        chk("core_hold", 64'(core_a), 64'd100);
      end else begin
        op_valid = 1'b0; op = 3'd0;
      end
      tick();
    end
    op_valid = 1'b0; op = 3'd0; cancel = 1'b0;
    chk("inflight_lat", 64'(nb), 64'd10);
    pop_chk("inflight_res");
    chk("perr_set", 64'(proto_err), 64'd1);
    tick(); tick(); tick();
    chk("perr_sticky", 64'(proto_err), 64'd1);
    chk("second_ignored", 64'(busy), 64'd0);
    $display("txn div-overlap hi=%h lo=%h perr=%b", hi, lo, proto_err);

    // 6: reset mid-op, then a fresh multiply
    issue(3'd1, 32'd3, 32'd4, 1'b0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_hilo", {hi, lo}, 64'd0);
    chk("midrst_perr", 64'(proto_err), 64'd0);
    tick(); tick(); tick(); tick(); tick();
    chk("midrst_nowrite", {hi, lo}, 64'd0);
    exp_q.push_back({32'd0, 32'd42});
    issue(3'd1, 32'd6, 32'd7, 1'b0);
    wait_done("post_rst_lat", 5, ns);
    pop_chk("post_rst_res");
    $display("txn reset-then-mult hi=%h lo=%h", hi, lo);

    // Reserved opcode
    issue(3'd7, 32'd0, 32'd0, 1'b0);
    chk("op7_perr", 64'(proto_err), 64'd1);
    chk("op7_busy", 64'(busy), 64'd0);
    $display("txn op7 perr=%b", proto_err);

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timed out");
  end

endmodule
